// File: rtl/arith_arbiter.sv
// arith_arbiter: round-robin sharing of one combinational add/sub unit between two requesters.
// Define ARITH_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module arith_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic last_gnt, gnt_id, winner, any_valid, accept;

    assign any_valid = req0_valid | req1_valid;
`ifdef ARITH_ARB_FIXED_PRIO_EN
    assign winner = !req0_valid;
`else
    // on a tie the requester that did not win last time is served
    assign winner = (req0_valid & req1_valid) ? !last_gnt : !req0_valid;
`endif
    assign accept     = (state == IDLE) && any_valid;
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            gnt_id    <= 1'b0;
            last_gnt  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_c     <= 1'b0;
            rsp_v     <= 1'b0;
        end else begin
            if (accept) begin
                alu_a    <= winner ? req1_a : req0_a;
                alu_b    <= winner ? req1_b : req0_b;
                alu_op   <= winner ? req1_op : req0_op;
                gnt_id   <= winner;
                last_gnt <= winner;
            end
            if (state == ISSUE) begin
                rsp_data  <= alu_out;
                rsp_c     <= alu_c;
                rsp_v     <= alu_v;
                rsp_id    <= gnt_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arith_arbiter.sv
// tb_arith_arbiter: directed checks of arith_arbiter with a behavioural add/sub unit attached.
module tb_arith_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        req0_ready, req1_ready, alu_c, alu_v, rsp_valid, rsp_id, rsp_c, rsp_v, busy;
    logic [31:0] alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]  alu_op;
    logic [32:0] sum;
    int n_chk = 0, n_pass = 0;

    arith_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_c(rsp_c), .rsp_v(rsp_v), .busy(busy)
    );

    always #5 clk = ~clk;

    // stand-in arithmetic unit: 4'b0011 subtracts, anything else adds
    always_comb begin
        sum = (alu_op == 4'b0011) ? {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1 : {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_out = sum[31:0];
    assign alu_c   = sum[32];
    assign alu_v   = (alu_op == 4'b0011) ? (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31])
                                         : (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] d, input logic c, input logic v);
        tick();
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk({tag, ".ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        chk({tag, ".other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk({tag, ".issue_busy"}, 32'(busy), 32'd1);
        chk({tag, ".issue_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".alu_a"}, alu_a, a);
        tick();
        #1;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_data"}, rsp_data, d);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, ".rsp_c"}, 32'(rsp_c), 32'(c));
        chk({tag, ".rsp_v"}, 32'(rsp_v), 32'(v));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic w;
        repeat (2) tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_data", rsp_data, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        reset = 1'b0;

        run_op("add", 1'b0, 32'd5, 32'd3, 4'b0001, 32'd8, 1'b0, 1'b0);
        run_op("sub", 1'b1, 32'd0, 32'd1, 4'b0011, 32'hFFFFFFFF, 1'b0, 1'b0);

        // both requesters valid continuously, responses consumed immediately
        tick();
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'b0001;
        req1_valid = 1'b1; req1_a = 32'd200; req1_b = 32'd50; req1_op = 4'b0011;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARITH_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = (i % 2) == 1;
`endif
            #1;
            chk($sformatf("rr%0d.ready0", i), 32'(req0_ready), 32'(!w));
            chk($sformatf("rr%0d.ready1", i), 32'(req1_ready), 32'(w));
            tick();
            tick();
            #1;
            chk($sformatf("rr%0d.rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr%0d.rsp_id", i), 32'(rsp_id), 32'(w));
            chk($sformatf("rr%0d.rsp_data", i), rsp_data, w ? 32'd150 : 32'd101);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

        run_op("ovf", 1'b0, 32'h7FFFFFFF, 32'd1, 4'b0001, 32'h80000000, 1'b0, 1'b1);

        // response back-pressure with the other requester waiting
        tick();
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_op = 4'b0011;
        #1;
        chk("bp.ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d.rsp_data", i), rsp_data, 32'd6);
            chk($sformatf("bp%0d.rsp_id", i), 32'(rsp_id), 32'd1);
            chk($sformatf("bp%0d.ready0", i), 32'(req0_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release_ready0", 32'(req0_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("bp.accept_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        chk("mid.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid.rsp_data", rsp_data, 32'd2);

        // asynchronous reset in RESP takes effect without a clock edge
        reset = 1'b1;
        #1;
        chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.alu_a", alu_a, 32'd0);
        chk("arst.alu_b", alu_b, 32'd0);
        chk("arst.alu_op", 32'(alu_op), 32'd0);
        chk("arst.rsp_data", rsp_data, 32'd0);
        chk("arst.rsp_id", 32'(rsp_id), 32'd0);
        chk("arst.rsp_cv", 32'({rsp_c, rsp_v}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        #1;
        chk("post.rsp_valid", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
